// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready output stream of fifo_stream_reader.
//   fifo_re      read enable toward the FIFO
//   fifo_r_data  FIFO read data, valid the cycle after fifo_re was sampled
//   fifo_empty   FIFO empty flag
//   m_valid/m_ready/m_data/m_last  downstream stream handshake, word and end-of-packet
// master = the reader, slave = the FIFO/consumer side.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_re;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    modport master (
        output fifo_re, m_valid, m_data, m_last,
        input  fifo_r_data, fifo_empty, m_ready
    );
    modport slave (
        input  fifo_re, m_valid, m_data, m_last,
        output fifo_r_data, fifo_empty, m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls FIFO words through a 2-entry skid buffer onto a valid/ready stream.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        fifo_stream_reader_if.master (FIFO read port + output stream)
//   pkt_count  completed packets, wraps at 2^16
//   busy       buffer occupied, read in flight, or not in STREAM
// Define FIFO_RD_FRAMING_EN to frame the stream into PKT_LEN-word packets separated by
// GAP_CYCLES idle cycles; otherwise reads run continuously and m_last/pkt_count stay 0.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus,
    output logic [15:0]          pkt_count,
    output logic                 busy
);
`ifdef FIFO_RD_FRAMING_EN
    localparam bit FRAMING = 1'b1;
`else
    localparam bit FRAMING = 1'b0;
`endif
    localparam int CW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
    localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {STREAM, DRAIN, GAP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d, beat_cnt_q, beat_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [15:0]           pkt_q, pkt_d;
    logic                  valid, pop, re, slot0;
    logic [2:0]            lvl;

    assign valid = occ_q != 2'd0;
    assign pop   = valid & bus.m_ready;
    // Entries the buffer will hold next cycle if nothing new is requested now.
    assign lvl   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    // Reset gating keeps the FIFO untouched while rst is held.
    assign re    = !rst & (state_q == STREAM) & !bus.fifo_empty & (lvl < 3'd2);
    // Arriving word lands at the head when the buffer is (or becomes) empty this cycle.
    assign slot0 = occ_q == {1'b0, pop};

    always_comb begin
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        inflight_d = re;
        head_d     = (inflight_q & slot0) ? bus.fifo_r_data : pop ? tail_q : head_q;
        tail_d     = (inflight_q & !slot0) ? bus.fifo_r_data : tail_q;
        beat_cnt_d = pop ? ((beat_cnt_q == LAST) ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pkt_d      = pkt_q;
        if (FRAMING) begin
            case (state_q)
                STREAM: if (re) begin
                    rd_cnt_d = (rd_cnt_q == LAST) ? '0 : rd_cnt_q + 1'b1;
                    state_d  = (rd_cnt_q == LAST) ? DRAIN : STREAM;
                end
                DRAIN: if (pop & (beat_cnt_q == LAST)) begin
                    pkt_d     = pkt_q + 16'd1;
                    gap_cnt_d = '0;
                    state_d   = GAP_CYCLES > 0 ? GAP : STREAM;
                end
                GAP: begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    state_d   = (gap_cnt_q == GLAST) ? STREAM : GAP;
                end
                default: state_d = STREAM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STREAM;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pkt_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pkt_q      <= pkt_d;
        end
    end

    assign bus.fifo_re = re;
    assign bus.m_valid = valid;
    assign bus.m_data  = head_q;
    assign bus.m_last  = FRAMING & valid & (beat_cnt_q == LAST);
    assign pkt_count   = pkt_q;
    assign busy        = valid | inflight_q | (state_q != STREAM);
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous FIFO. It pulls words from the FIFO read port (`re`/`r_data`/`empty`) and presents them to a downstream consumer on a valid/ready stream. It hides the FIFO's one-cycle read latency behind a 2-entry output buffer and optionally frames the stream into fixed-length packets separated by idle gaps. It sits between the FIFO and any consumer that must not see underrun.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `PKT_LEN`, 4, words per packet (≥1); used only with framing.
- `GAP_CYCLES`, 2, idle cycles between packets (≥0); used only with framing.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_re`  out  1  read enable to the FIFO.
- `fifo_r_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after the edge that sampled `fifo_re=1`.
- `fifo_empty`  in  1  FIFO empty flag.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  final word of a packet.
- `pkt_count`  out  16  completed packets, wraps at 2^16.
- `busy`  out  1  buffer occupied, read in flight, or FSM not in STREAM.

## Operation
- Reset values: `fifo_re=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `pkt_count=0`, `busy=0`. FSM=STREAM, occupancy=0, in-flight=0, counters=0. In-flight read data is discarded. FIFO contents are untouched.
- Output buffer: 2-entry FIFO-ordered (skid) buffer. `occ` is 0..2. `inflight` is 1 on the cycle after an issued read.
- Pop: `pop = m_valid & m_ready`.
- Read issue, combinational: `fifo_re = (state==STREAM) & !fifo_empty & (occ + inflight - pop < 2)`. This is a permitted combinational path from `m_ready` to `fifo_re`.
- Capture: `fifo_r_data` is written into the buffer on the edge after the cycle `inflight=1`. Simultaneous capture and pop is legal; `occ` stays the same.
- Output handshake: `m_valid = (occ != 0)`. `m_data` is the head entry. `m_data`/`m_last` are held stable while `m_valid & !m_ready`.
- Underrun: `fifo_re` is never asserted while `fifo_empty=1`.
- Overflow: the buffer never exceeds 2 entries.
- FSM states (with framing):
  - STREAM: issue reads and count issued reads in `rd_cnt`. When a read issues with `rd_cnt==PKT_LEN-1`, clear `rd_cnt` and go to DRAIN.
  - DRAIN: no reads. When the word with `beat_cnt==PKT_LEN-1` pops, increment `pkt_count`, then go to GAP if `GAP_CYCLES>0`, else STREAM.
  - GAP: no reads. After `GAP_CYCLES` cycles, go to STREAM.
- `beat_cnt` counts popped words modulo PKT_LEN. `m_last = m_valid & (beat_cnt==PKT_LEN-1)`.
- `PKT_LEN=1`: every word is last, and every read moves the FSM to DRAIN.
- Reset mid-packet: partial packet is abandoned, counters clear, and the next packet starts counting from the next word read after reset.

## Timing
- `fifo_re` high in cycle c → data captured at the end of c+1 → `m_valid=1` in cycle c+2. First-word latency is 2 cycles from read issue.
- Throughput: 1 word/cycle sustained within a packet while `m_ready=1` and FIFO non-empty.
- Per-packet overhead with framing: pipeline drain (≤2 cycles) + GAP_CYCLES + 1 cycle re-entry to STREAM.
- Consumer stall: at most 2 words are buffered; reads stop within the same cycle via the `pop` term.

## Configuration
- `FIFO_RD_FRAMING_EN` defined: packet framing as above (STREAM/DRAIN/GAP, `m_last`, `pkt_count`).
- `FIFO_RD_FRAMING_EN` undefined:
  - FSM permanently STREAM; reads continuous whenever allowed.
  - `m_last` tied 0; `pkt_count` tied 0.
  - `PKT_LEN`/`GAP_CYCLES` ignored.

## Test plan
- Reset, FIFO empty for 10 cycles → `fifo_re=0`, `m_valid=0`, `busy=0` throughout.
- FIFO pre-loaded with 0x11,0x22,0x33, `m_ready=1`, framing off → `m_data` 0x11,0x22,0x33 on consecutive cycles. First `m_valid` is 2 cycles after first `fifo_re`. `fifo_re` drops when empty.
- 8 words, `m_ready=0` for 6 cycles then 1 → exactly 2 reads issued during stall. No word lost or duplicated. `m_data` stable during stall.
- Framing on, PKT_LEN=4, GAP_CYCLES=2, 8 words → `m_last` on words 4 and 8, `pkt_count`=2. `fifo_re` stays low for ≥2 cycles between packets.
- Random `m_ready` with FIFO alternately empty and non-empty, 200 words → output order equals write order. `fifo_re` is never asserted with `fifo_empty=1`.
- `rst` asserted mid-packet (word 2 of 4) → all outputs return to reset values next cycle. The following packet's `m_last` falls on its 4th word.
